if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_pkg.sv | 13 +
 rtl/branch_target_adder.sv | 14 +
 rtl/if_stage.sv | 114 +++++++++++
 tb/tb_if_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared fetch-stage definitions: FSM state encodings, PC step and reset PC.
package if_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  localparam int unsigned PC_INC = 4;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

endpackage

// File: rtl/branch_target_adder.sv
// Branch target: br_pc plus word offset scaled to bytes, modulo 2^PC_W.
module branch_target_adder #(
  parameter int unsigned PC_W = 64
) (
  input  logic [PC_W-1:0] br_pc,
  input  logic [PC_W-1:0] br_offset,
  output logic [PC_W-1:0] target
);

  always_comb begin
    target = br_pc + (br_offset << 2);
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, single-entry output
// register toward decode, branch redirect with in-flight response dropping.
module if_stage
  import if_pkg::*;
#(
  parameter int unsigned     PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [31:0]     imem_rdata,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_pc,
  input  logic [PC_W-1:0] br_offset,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [PC_W-1:0] if_pc,
  input  logic            id_ready
);

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic            if_valid_q, if_valid_d;
  logic [31:0]     if_instr_q, if_instr_d;
  logic [PC_W-1:0] if_pc_q, if_pc_d;
  logic [PC_W-1:0] target;

  branch_target_adder #(
    .PC_W(PC_W)
  ) u_bta (
    .br_pc    (br_pc),
    .br_offset(br_offset),
    .target   (target)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (br_taken) begin
          pc_d       = target;
          if_valid_d = 1'b0;
          state_d    = imem_valid ? S_REQ : S_DROP;
        end else if (imem_valid) begin
          if_instr_d = imem_rdata;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + PC_W'(PC_INC);
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (br_taken) begin
          pc_d       = target;
          if_valid_d = 1'b0;
          state_d    = S_REQ;
        end else if (id_ready) begin
          if_valid_d = 1'b0;
          state_d    = S_REQ;
        end
      end
      S_DROP: begin
        if (br_taken) begin
          pc_d       = target;
          if_valid_d = 1'b0;
        end
        if (imem_valid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The abandoned request stays on the bus while dropping; otherwise addr tracks pc.
    addr_d = (state_d == S_DROP) ? addr_q : pc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  always_comb begin
    imem_req  = (state_q == S_REQ) || (state_q == S_DROP);
    imem_addr = addr_q;
    if_valid  = if_valid_q;
    if_instr  = if_instr_q;
    if_pc     = if_pc_q;
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a scoreboard of expected fetched words.
module tb_if_stage;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        br_taken = 1'b0;
  logic [63:0] br_pc = '0;
  logic [63:0] br_offset = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        id_ready = 1'b1;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic prev_v = 1'b0;

  if_stage #(
    .PC_W    (64),
    .RESET_PC(64'h0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_valid(imem_valid),
    .imem_rdata(imem_rdata),
    .br_taken  (br_taken),
    .br_pc     (br_pc),
    .br_offset (br_offset),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .id_ready  (id_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Each new output presentation must match the oldest expected fetch.
  always @(negedge clk) begin
    if (if_valid && !prev_v) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output got pc=%h instr=%h required no output", if_pc, if_instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (if_instr !== e.instr || if_pc !== e.pc) begin
          miscompares++;
          $display("FAIL fetch_word got pc=%h instr=%h required pc=%h instr=%h",
                   if_pc, if_instr, e.pc, e.instr);
        end
      end
    end
    prev_v = if_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  task automatic branch(input logic [63:0] bpc, input logic [63:0] boff);
    br_taken  = 1'b1;
    br_pc     = bpc;
    br_offset = boff;
  endtask

  // Check the pending request, expect its word, then respond after lat idle cycles.
  task automatic serve(input logic [63:0] a, input logic [31:0] w, input int unsigned lat);
    exp_t e;
    chk("req_high", {63'd0, imem_req}, 64'd1);
    chk("req_addr", imem_addr, a);
    e.instr = w;
    e.pc    = a;
    sb.push_back(e);
    for (int unsigned i = 0; i < lat; i++) begin
      tick();
      chk("addr_stable", imem_addr, a);
    end
    imem_valid = 1'b1;
    imem_rdata = w;
    tick();
    imem_valid = 1'b0;
    imem_rdata = '0;
  endtask

  logic [31:0] seq_words [3] = '{32'h0000_0013, 32'h0040_0093, 32'h0080_0113};

  initial begin
    #2;
    chk("rst_req", {63'd0, imem_req}, 64'd0);
    chk("rst_addr", imem_addr, 64'h0);
    chk("rst_valid", {63'd0, if_valid}, 64'd0);
    tick();
    rst_n = 1'b1;
    chk("idle_req", {63'd0, imem_req}, 64'd0);
    tick();

    // Sequential fetch with id_ready held high.
    for (int i = 0; i < 3; i++) begin
      serve(64'(4 * i), seq_words[i], 1);
      chk("out_valid", {63'd0, if_valid}, 64'd1);
      tick();
      chk("gap_valid", {63'd0, if_valid}, 64'd0);
    end

    // Decode stall holds the output.
    id_ready = 1'b0;
    serve(64'hC, 32'h00C0_0193, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_instr", {32'd0, if_instr}, {32'd0, 32'h00C0_0193});
      chk("stall_pc", if_pc, 64'hC);
      chk("stall_req", {63'd0, imem_req}, 64'd0);
      chk("stall_nextpc", imem_addr, 64'h10);
    end
    id_ready = 1'b1;
    tick();

    // Redirect in S_OUT, backward offset.
    serve(64'h10, 32'h0100_0213, 0);
    branch(64'h100, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    br_taken = 1'b0;
    chk("out_br_valid", {63'd0, if_valid}, 64'd0);
    chk("out_br_addr", imem_addr, 64'hF8);

    // Redirect in S_REQ, response three cycles later is dropped.
    branch(64'h200, 64'h4);
    tick();
    br_taken = 1'b0;
    chk("drop_state", {62'd0, dut.state_q}, {62'd0, S_DROP});
    chk("drop_old_addr", imem_addr, 64'hF8);
    chk("drop_req", {63'd0, imem_req}, 64'd1);
    tick();
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_valid = 1'b0;
    chk("drop_exit_state", {62'd0, dut.state_q}, {62'd0, S_REQ});
    chk("drop_exit_addr", imem_addr, 64'h210);
    serve(64'h210, 32'h0210_0293, 0);
    tick();

    // A second redirect while dropping replaces the latched target.
    branch(64'h300, 64'h0);
    tick();
    chk("drop2_state", {62'd0, dut.state_q}, {62'd0, S_DROP});
    branch(64'h400, 64'h1);
    tick();
    br_taken = 1'b0;
    chk("drop2_stay", {62'd0, dut.state_q}, {62'd0, S_DROP});
    chk("drop2_old_addr", imem_addr, 64'h214);
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    chk("drop2_target", imem_addr, 64'h404);

    // Redirect coinciding with the response: no drop state.
    branch(64'h500, 64'h0);
    imem_valid = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    tick();
    br_taken   = 1'b0;
    imem_valid = 1'b0;
    chk("coinc_state", {62'd0, dut.state_q}, {62'd0, S_REQ});
    chk("coinc_addr", imem_addr, 64'h500);
    chk("coinc_valid", {63'd0, if_valid}, 64'd0);
    serve(64'h500, 32'h0500_0313, 0);

    // PC wraps from the top of the address space.
    branch(64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    br_taken = 1'b0;
    serve(64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFC_0393, 0);
    tick();
    chk("wrap_addr", imem_addr, 64'h0);

    // Asynchronous reset while dropping.
    branch(64'h600, 64'h0);
    tick();
    br_taken = 1'b0;
    chk("pre_rst_state", {62'd0, dut.state_q}, {62'd0, S_DROP});
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {63'd0, imem_req}, 64'd0);
    chk("arst_addr", imem_addr, 64'h0);
    chk("arst_valid", {63'd0, if_valid}, 64'd0);
    chk("arst_instr", {32'd0, if_instr}, 64'd0);
    chk("arst_pc", if_pc, 64'h0);
    chk("arst_state", {62'd0, dut.state_q}, {62'd0, S_IDLE});
    tick();
    rst_n = 1'b1;
    chk("rerel_idle_req", {63'd0, imem_req}, 64'd0);
    tick();
    chk("rerel_req", {63'd0, imem_req}, 64'd1);
    chk("rerel_addr", imem_addr, 64'h0);
    tick();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
